dev_int_ctrl: RTL and testbench
===============================

DEV_INT_CTRL -- requirements
Module: dev_int_ctrl

Interface
REQ-001 SHALL have parameter NSRC, default 8, giving the number of interrupt sources; the only legal value is 8.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port dev_out, output, 32 bits: register read data.
REQ-005 SHALL have port dev_in, input, 32 bits: register write data.
REQ-006 SHALL have port dev_addr, input, 8 bits: byte offset within the 256-byte device window; decode on dev_addr[7:2] only.
REQ-007 SHALL have port dev_we, input, 1 bit: write strobe, sampled on the rising edge of clk.
REQ-008 SHALL have port irq_src, input, 8 bits: interrupt requests, synchronous to clk; bit i is source i.
REQ-009 SHALL have port irq_out, output, 1 bit: aggregated interrupt request to one CPU ext_int line.

Function
REQ-010 SHALL provide this register map (offsets):
- 0x00 ENABLE: R/W, bits[7:0].
- 0x04 MODE: R/W, bits[7:0]; 1 = rising-edge mode, 0 = level mode.
- 0x08 PENDING: R; write-1-to-clear bits[7:0].
- 0x0C INSERV: R only.
- 0x10 CLAIM: R returns {valid at bit31, 28'b0, id[2:0]}; a write of any value performs a claim.
- 0x14 EOI: W; dev_in[2:0] = id of the source to retire.
REQ-011 SHALL return dev_out combinationally from the current registers; unused bits read 0; unmapped offsets read 0x00000000.
REQ-012 SHALL ignore writes to unmapped or read-only offsets.
REQ-013 SHALL register irq_src into src_q every cycle; rising edge i = irq_src[i] & ~src_q[i].
REQ-014 Edge-mode pending[i]: SHALL be set on a rising edge; SHALL stay set until cleared by W1C or claim.
REQ-015 Level-mode pending[i]: SHALL be loaded with irq_src[i] every cycle, so W1C and claim have only a one-cycle effect while the source stays high.
REQ-016 Pending bits SHALL be set regardless of ENABLE; ENABLE gates arbitration only.
REQ-017 If a set event and a clear (W1C or claim) on the same bit coincide in one cycle, the set SHALL win.
REQ-018 Priority: SHALL be fixed, index 0 highest, 7 lowest.
REQ-019 cand = pending & ENABLE; best = lowest set index of cand; valid = cand != 0 and best has higher priority than the highest-priority set bit of INSERV (or INSERV == 0).
REQ-020 irq_out SHALL equal valid, derived combinationally from registered state; irq_out therefore asserts the cycle after the edge that sets pending.
REQ-021 Claim write with valid = 1: at that edge SHALL set INSERV[best] and clear pending[best]; with valid = 0: no effect.
REQ-022 EOI write SHALL clear INSERV[dev_in[2:0]]; EOI of a bit that is not in service SHALL have no effect.
REQ-023 Nesting: a higher-priority source SHALL be claimable while lower ones are in service; equal or lower priority SHALL be blocked until EOI.
REQ-024 Disabling ENABLE[i] SHALL NOT alter pending[i] or INSERV[i].
REQ-025 MODE change SHALL take effect at the next edge; no pending bits are cleared by the change.

Reset
REQ-026 On rst = 1, regardless of clk, SHALL clear ENABLE, MODE, PENDING, INSERV and src_q to 0, so irq_out = 0 and CLAIM reads 0x00000000.
REQ-027 Reset mid-service SHALL discard all in-service state; no EOI is required after release.
REQ-028 On release, an irq_src bit already high SHALL count as a rising edge at the first clock edge (src_q = 0).

Verification
REQ-029 Edge basic: ENABLE = 0x01, MODE = 0x01, pulse irq_src[0] for 1 cycle -> PENDING = 0x01, irq_out = 1 the next cycle, CLAIM reads 0x80000000; claim write -> INSERV = 0x01, PENDING = 0, irq_out = 0; EOI 0 -> INSERV = 0.
REQ-030 Priority/nesting: ENABLE = 0xFF, MODE = 0xFF, edges on sources 5 and 2 in the same cycle -> CLAIM id = 2; claim -> irq_out = 0 (5 is lower priority); edge on source 0 -> irq_out = 1; claim -> INSERV = 0x05; EOI 0, EOI 2 -> CLAIM id = 5, valid.
REQ-031 Level mode: MODE = 0, ENABLE = 0x80, hold irq_src[7] = 1 -> PENDING = 0x80; W1C 0x80 -> reads 0x80 again one cycle later; drop source -> PENDING = 0 next cycle.
REQ-032 Masking and collision: ENABLE = 0, edge on source 3 -> PENDING = 0x08, irq_out = 0; W1C 0x08 in the same cycle as a new edge on source 3 -> PENDING stays 0x08; ENABLE = 0x08 -> irq_out = 1.
REQ-033 Async reset: INSERV = 0x02 and PENDING = 0x10; assert rst between clock edges -> all registers 0 and irq_out = 0 immediately; irq_src[4] held high through release -> PENDING = 0x10 after the first edge (MODE = 0 after reset, level).

Source files
------------

// File: rtl/dev_int_ctrl.sv
// dev_int_ctrl: eight-source interrupt controller with fixed priority,
// per-source edge/level mode, claim/EOI handshake and nested service.
module dev_int_ctrl #(
    parameter int NSRC = 8
) (
    input  logic            clk,
    input  logic            rst,
    output logic [31:0]     dev_out,
    input  logic [31:0]     dev_in,
    input  logic [7:0]      dev_addr,
    input  logic            dev_we,
    input  logic [NSRC-1:0] irq_src,
    output logic            irq_out
);

    localparam logic [5:0] A_ENABLE  = 6'd0;
    localparam logic [5:0] A_MODE    = 6'd1;
    localparam logic [5:0] A_PENDING = 6'd2;
    localparam logic [5:0] A_INSERV  = 6'd3;
    localparam logic [5:0] A_CLAIM   = 6'd4;
    localparam logic [5:0] A_EOI     = 6'd5;

    logic [NSRC-1:0] enable_q, enable_d;
    logic [NSRC-1:0] mode_q, mode_d;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] insv_q, insv_d;
    logic [NSRC-1:0] src_q;

    logic [5:0]      addr;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] cand;
    logic [NSRC-1:0] clr;
    logic [NSRC-1:0] claim_clr;
    logic [2:0]      best;
    logic [2:0]      insv_top;
    logic            valid;
    logic            claim_fire;
    logic            unused_bits;

    assign addr        = dev_addr[7:2];
    assign rise        = irq_src & ~src_q;
    assign cand        = pend_q & enable_q;
    assign claim_fire  = dev_we && (addr == A_CLAIM) && valid;
    assign irq_out     = valid;
    assign unused_bits = ^{dev_in[31:NSRC], dev_addr[1:0]};

    // Fixed priority: lowest index wins, for candidates and in-service.
    always_comb begin
        best     = 3'd0;
        insv_top = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (cand[i]) best = 3'(i);
            if (insv_q[i]) insv_top = 3'(i);
        end
        valid = (cand != '0) && ((insv_q == '0) || (best < insv_top));
    end

    // Register writes, claim and EOI bookkeeping.
    always_comb begin
        enable_d  = enable_q;
        mode_d    = mode_q;
        insv_d    = insv_q;
        claim_clr = '0;
        if (claim_fire) begin
            claim_clr[best] = 1'b1;
            insv_d[best]    = 1'b1;
        end
        if (dev_we) begin
            if (addr == A_ENABLE) enable_d = dev_in[NSRC-1:0];
            if (addr == A_MODE) mode_d = dev_in[NSRC-1:0];
            if (addr == A_EOI) insv_d[dev_in[2:0]] = 1'b0;
        end
    end

    // Pending update: edge mode latches until cleared (set wins), level follows source.
    always_comb begin
        clr    = claim_clr;
        pend_d = pend_q;
        if (dev_we && (addr == A_PENDING)) clr = clr | dev_in[NSRC-1:0];
        for (int i = 0; i < NSRC; i++) begin
            if (mode_q[i]) pend_d[i] = rise[i] | (pend_q[i] & ~clr[i]);
            else           pend_d[i] = irq_src[i];
        end
    end

    // Read mux straight from current state.
    always_comb begin
        dev_out = '0;
        case (addr)
            A_ENABLE:  dev_out[NSRC-1:0] = enable_q;
            A_MODE:    dev_out[NSRC-1:0] = mode_q;
            A_PENDING: dev_out[NSRC-1:0] = pend_q;
            A_INSERV:  dev_out[NSRC-1:0] = insv_q;
            A_CLAIM:   dev_out = {valid, 28'b0, best};
            default:   dev_out = '0;
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_q <= '0;
            mode_q   <= '0;
            pend_q   <= '0;
            insv_q   <= '0;
            src_q    <= '0;
        end else begin
            enable_q <= enable_d;
            mode_q   <= mode_d;
            pend_q   <= pend_d;
            insv_q   <= insv_d;
            src_q    <= irq_src;
        end
    end

endmodule

// File: tb/tb_dev_int_ctrl.sv
// tb_dev_int_ctrl: directed scenarios for dev_int_ctrl with a
// tag/expected scoreboard queue popped when the DUT output is sampled.
module tb_dev_int_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] dev_out;
    logic [31:0] dev_in;
    logic [7:0]  dev_addr;
    logic        dev_we;
    logic [7:0]  irq_src;
    logic        irq_out;

    int checks;
    int failures;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    dev_int_ctrl #(.NSRC(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .dev_out  (dev_out),
        .dev_in   (dev_in),
        .dev_addr (dev_addr),
        .dev_we   (dev_we),
        .irq_src  (irq_src),
        .irq_out  (irq_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic expect_val(input string tag, input logic [31:0] e);
        tag_q.push_back(tag);
        exp_q.push_back(e);
    endtask

    task automatic observe(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty obs=%h exp=none", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s obs=%h exp=%h", t, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        dev_addr = a;
        dev_in   = d;
        dev_we   = 1'b1;
        tick();
        dev_we   = 1'b0;
        dev_in   = '0;
    endtask

    task automatic rd(input string tag, input logic [7:0] a,
                      input logic [31:0] e);
        expect_val(tag, e);
        dev_addr = a;
        #1;
        observe(dev_out);
    endtask

    task automatic chk_irq(input string tag, input logic e);
        expect_val(tag, {31'b0, e});
        observe({31'b0, irq_out});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        dev_in   = '0;
        dev_addr = '0;
        dev_we   = 1'b0;
        irq_src  = '0;
        #2;
        chk_irq("rst_irq", 1'b0);
        rd("rst_claim", 8'h10, 32'h0);
        rd("rst_enable", 8'h00, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // map sanity
        wr(8'h00, 32'h0000_0001);
        wr(8'h04, 32'h0000_0001);
        rd("addr_lowbits", 8'h03, 32'h1);
        wr(8'h1C, 32'hFFFF_FFFF);
        wr(8'h0C, 32'hFFFF_FFFF);
        rd("unmapped_rd", 8'h18, 32'h0);
        rd("unmapped_wr", 8'h00, 32'h1);
        rd("ro_inserv", 8'h0C, 32'h0);
        rd("mode_rd", 8'h04, 32'h1);

        // edge basic
        irq_src = 8'h01;
        tick();
        irq_src = 8'h00;
        rd("e_pend", 8'h08, 32'h01);
        chk_irq("e_irq", 1'b1);
        rd("e_claim", 8'h10, 32'h8000_0000);
        wr(8'h10, 32'h0);
        rd("e_insv", 8'h0C, 32'h01);
        rd("e_pend0", 8'h08, 32'h00);
        chk_irq("e_irq0", 1'b0);
        wr(8'h14, 32'h0);
        rd("e_eoi", 8'h0C, 32'h00);

        // priority and nesting
        wr(8'h00, 32'hFF);
        wr(8'h04, 32'hFF);
        irq_src = 8'h24;
        tick();
        irq_src = 8'h00;
        rd("n_claim2", 8'h10, 32'h8000_0002);
        wr(8'h10, 32'h0);
        chk_irq("n_block5", 1'b0);
        rd("n_pend5", 8'h08, 32'h20);
        irq_src = 8'h01;
        tick();
        irq_src = 8'h00;
        chk_irq("n_irq0", 1'b1);
        rd("n_claim0", 8'h10, 32'h8000_0000);
        wr(8'h10, 32'h0);
        rd("n_insv05", 8'h0C, 32'h05);
        wr(8'h14, 32'h0);
        wr(8'h14, 32'h2);
        rd("n_claim5", 8'h10, 32'h8000_0005);
        wr(8'h14, 32'h3);
        rd("n_eoi_idle", 8'h0C, 32'h00);
        wr(8'h10, 32'h0);
        wr(8'h14, 32'h5);
        rd("n_clean", 8'h0C, 32'h00);

        // level mode
        wr(8'h04, 32'h00);
        wr(8'h00, 32'h80);
        irq_src = 8'h80;
        tick();
        rd("l_pend", 8'h08, 32'h80);
        chk_irq("l_irq", 1'b1);
        wr(8'h08, 32'h80);
        tick();
        rd("l_reload", 8'h08, 32'h80);
        irq_src = 8'h00;
        tick();
        rd("l_drop", 8'h08, 32'h00);

        // masking and collision
        wr(8'h00, 32'h00);
        wr(8'h04, 32'h08);
        irq_src = 8'h08;
        tick();
        irq_src = 8'h00;
        tick();
        rd("m_pend", 8'h08, 32'h08);
        chk_irq("m_masked", 1'b0);
        irq_src = 8'h08;
        wr(8'h08, 32'h08);
        irq_src = 8'h00;
        tick();
        rd("m_collide", 8'h08, 32'h08);
        wr(8'h00, 32'h08);
        chk_irq("m_unmask", 1'b1);
        wr(8'h00, 32'h00);
        rd("m_dis_keep", 8'h08, 32'h08);
        wr(8'h00, 32'h08);
        wr(8'h08, 32'h08);
        rd("m_w1c", 8'h08, 32'h00);
        chk_irq("m_w1c_irq", 1'b0);

        // async reset mid-service
        wr(8'h04, 32'h12);
        wr(8'h00, 32'h02);
        irq_src = 8'h12;
        tick();
        irq_src = 8'h00;
        wr(8'h10, 32'h0);
        rd("r_insv", 8'h0C, 32'h02);
        rd("r_pend", 8'h08, 32'h10);
        irq_src = 8'h10;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_irq("r_irq", 1'b0);
        rd("r_enable", 8'h00, 32'h0);
        rd("r_mode", 8'h04, 32'h0);
        rd("r_pend0", 8'h08, 32'h0);
        rd("r_insv0", 8'h0C, 32'h0);
        rd("r_claim0", 8'h10, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        rd("r_release", 8'h08, 32'h10);
        chk_irq("r_rel_irq", 1'b0);
        irq_src = 8'h00;

        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_left obs=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
